shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-pass controller directly upstream of the team's combinational Shifter.
- The Shifter is a logical left shift of a 32-bit word by 0..15 (4-bit shift_amount).
- This block accepts shift requests up to 63 positions over a valid/ready handshake.
- It splits each request into passes of at most 15, feeds the Shifter one pass per cycle, recirculates the Shifter's result, and returns the final word over a valid/ready response.

Parameters:
- DATA_W, 32: datapath width; must match Shifter data width.
- AMT_W, 6: request shift-amount width; maximum request is 2^AMT_W-1.
- STEP_MAX, 15: largest amount per Shifter pass; equals 2^4-1 for the 4-bit Shifter port.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_data  input  DATA_W  word to shift.
- req_amount  input  AMT_W  total left-shift amount.
- sh_data_in  output  DATA_W  to Shifter data_in.
- sh_shift_amount  output  4  to Shifter shift_amount.
- sh_shifted_data  input  DATA_W  from Shifter shifted_data.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  DATA_W  shifted result.
- rsp_passes  output  3  number of Shifter passes used.

Behaviour:
- Reset: clk and rst as above; rst is asynchronous and active-high, every flop clears immediately on assertion.
- State after reset is IDLE, work_reg=0, remaining=0, rsp_data=0, rsp_passes=0, rsp_valid=0, req_ready=1, sh_data_in=0, sh_shift_amount=0.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: work_reg<=req_data, remaining<=req_amount, pass_cnt<=0.
  - Go to SHIFT if req_amount!=0, else DONE.
- SHIFT:
  - req_ready=0.
  - step = min(remaining, STEP_MAX), computed combinationally.
  - sh_data_in=work_reg, sh_shift_amount=step.
  - Each cycle: work_reg<=sh_shifted_data, remaining<=remaining-step, pass_cnt<=pass_cnt+1.
  - When remaining-step==0, go to DONE.
- DONE:
  - rsp_valid=1, rsp_data=work_reg, rsp_passes=pass_cnt; req_ready=0.
  - Outputs stay stable while rsp_ready=0.
  - On rsp_ready, go to IDLE. No new request is accepted in the same cycle.
- Outside SHIFT, sh_data_in=0 and sh_shift_amount=0.
- Latency: P=ceil(A/STEP_MAX). rsp_valid rises P+1 cycles after the accept edge; A=0 gives P=0 and 1 cycle.
- Arithmetic: remaining is unsigned AMT_W bits and never underflows because step<=remaining. pass_cnt saturates at its width (max 5 for AMT_W=6).
- No overlap: exactly one request is in flight. Throughput is one request per P+2 cycles when rsp_ready=1.
- Reset mid-SHIFT or mid-DONE aborts the operation; the result is discarded and the block returns to the reset state.

Optional Feature:
- Macro SHIFT_SAT_SHORTCUT_EN.
- Defined: in IDLE, a request with req_amount>=DATA_W loads work_reg<=0, pass_cnt<=0 and goes directly to DONE. rsp_data=0 and rsp_passes=0, 1 cycle after accept.
- Not defined: such requests run all passes through the Shifter. The result is still 0, but takes ceil(A/15) passes.

Decomposition:
- Package shift_pkg holds:
  - DATA_W, STEP_MAX and the shift amount width (4).
  - The state enum {IDLE, SHIFT, DONE}.
  - A min-step function.
- One sub-module is natural: shift_step_calc, combinational, (remaining) -> (step, last_pass).
- The Shifter is instantiated beside this block at the top level, not inside it.

Test Plan:
- 0x0000000B, amount 4, rsp_ready=1 -> one pass with sh_shift_amount=4. rsp_data=0x000000B0, rsp_passes=1, rsp_valid 2 cycles after accept.
- 0x0000000B, amount 20 -> passes of 15 then 5. rsp_data=0x00B00000, rsp_passes=2, rsp_valid 3 cycles after accept.
- 0x0000000B, amount 0 -> no Shifter activity (sh_shift_amount stays 0). rsp_data=0x0000000B, rsp_passes=0, rsp_valid 1 cycle after accept.
- 0xFFFFFFFF, amount 40:
  - With SHIFT_SAT_SHORTCUT_EN: rsp_data=0, rsp_passes=0 after 1 cycle.
  - Without it: passes 15, 15, 10; rsp_data=0, rsp_passes=3 after 4 cycles.
- Amount 4 result with rsp_ready held low 5 cycles -> rsp_valid, rsp_data=0xB0 and rsp_passes stay stable, req_ready=0 throughout. A second req_valid is ignored until one cycle after rsp_ready.
- Amount 63 request, rst asserted during the 2nd SHIFT cycle -> all outputs reset values immediately, req_ready=1. The next request of 0x1 with amount 1 returns 0x2.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants, state encoding and step helper for the multi-pass shift sequencer.
package shift_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned AMT_W    = 6;
  localparam int unsigned SH_AMT_W = 4;
  localparam int unsigned STEP_MAX = 15;
  localparam int unsigned PASS_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned min_step(input int unsigned rem, input int unsigned lim);
    return (rem < lim) ? rem : lim;
  endfunction

endpackage

// File: rtl/shift_step_calc.sv
// Per-pass step size: clamps the remaining shift to what one Shifter pass can do.
module shift_step_calc
  import shift_pkg::*;
#(
  parameter int unsigned AMT_W    = shift_pkg::AMT_W,
  parameter int unsigned STEP_MAX = shift_pkg::STEP_MAX
) (
  input  logic [AMT_W-1:0]    remaining_i,
  output logic [SH_AMT_W-1:0] step_o,
  output logic                last_pass_o
);

  always_comb begin
    step_o      = SH_AMT_W'(min_step(32'(remaining_i), 32'(STEP_MAX)));
    last_pass_o = (32'(remaining_i) <= 32'(STEP_MAX));
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass controller feeding the 4-bit-amount Shifter one pass per cycle.
// Optional build macro SHIFT_SAT_SHORTCUT_EN: amounts >= DATA_W skip straight to a zero result.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | one Shifter pass per cycle, result recirculated
// DONE  | result held until rsp_ready
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W   = shift_pkg::DATA_W,
  parameter int unsigned AMT_W    = shift_pkg::AMT_W,
  parameter int unsigned STEP_MAX = shift_pkg::STEP_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [AMT_W-1:0]    req_amount,
  output logic [DATA_W-1:0]   sh_data_in,
  output logic [SH_AMT_W-1:0] sh_shift_amount,
  input  logic [DATA_W-1:0]   sh_shifted_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [PASS_W-1:0]   rsp_passes
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [SH_AMT_W-1:0] step;
  logic                last_pass;

  shift_step_calc #(
    .AMT_W    (AMT_W),
    .STEP_MAX (STEP_MAX)
  ) u_step (
    .remaining_i (rem_q),
    .step_o      (step),
    .last_pass_o (last_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    work_d          = work_q;
    rem_d           = rem_q;
    pass_d          = pass_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_data        = '0;
    rsp_passes      = '0;
    sh_data_in      = '0;
    sh_shift_amount = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          work_d  = req_data;
          rem_d   = req_amount;
          pass_d  = '0;
          state_d = (req_amount != '0) ? SHIFT : DONE;
`ifdef SHIFT_SAT_SHORTCUT_EN
          if (32'(req_amount) >= 32'(DATA_W)) begin
            work_d  = '0;
            rem_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        sh_data_in      = work_q;
        sh_shift_amount = step;
        work_d          = sh_shifted_data;
        rem_d           = rem_q - AMT_W'(step);
        // pass count saturates rather than wrapping
        pass_d          = (pass_q == '1) ? pass_q : pass_q + 1'b1;
        if (last_pass) state_d = DONE;
      end
      DONE: begin
        rsp_valid  = 1'b1;
        rsp_data   = work_q;
        rsp_passes = pass_q;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural Shifter beside it.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [5:0]  req_amount;
  logic [31:0] sh_data_in;
  logic [3:0]  sh_shift_amount;
  logic [31:0] sh_shifted_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_passes;

  int checks   = 0;
  int failures = 0;

  shift_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data),
    .req_amount      (req_amount),
    .sh_data_in      (sh_data_in),
    .sh_shift_amount (sh_shift_amount),
    .sh_shifted_data (sh_shifted_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_passes      (rsp_passes)
  );

  assign sh_shifted_data = sh_data_in << sh_shift_amount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     data;
    logic [5:0]      amount;
    logic [31:0]     exp_data;
    logic [2:0]      exp_passes;
    int              exp_lat;
    logic [4:0][3:0] steps;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0][3:0] st(input int a, input int b, input int c,
                                         input int d, input int e);
    logic [4:0][3:0] s;
    s[0] = 4'(a); s[1] = 4'(b); s[2] = 4'(c); s[3] = 4'(d); s[4] = 4'(e);
    return s;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    req_data   = v.data;
    req_amount = v.amount;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (lat <= 5) chk("pass_amount", 32'(sh_shift_amount), 32'(v.steps[lat-1]));
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_passes", 32'(rsp_passes), 32'(v.exp_passes));
    chk("done_sh_amount", 32'(sh_shift_amount), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("back_idle_valid", 32'(rsp_valid), 32'd0);
    chk("back_idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000000B, 6'd4,  32'h000000B0, 3'd1, 2, st(4, 0, 0, 0, 0)};
    vecs[1] = '{32'h0000000B, 6'd20, 32'h00B00000, 3'd2, 3, st(15, 5, 0, 0, 0)};
    vecs[2] = '{32'h0000000B, 6'd0,  32'h0000000B, 3'd0, 1, st(0, 0, 0, 0, 0)};
`ifdef SHIFT_SAT_SHORTCUT_EN
    vecs[3] = '{32'hFFFFFFFF, 6'd40, 32'h00000000, 3'd0, 1, st(0, 0, 0, 0, 0)};
    vecs[4] = '{32'h00000001, 6'd63, 32'h00000000, 3'd0, 1, st(0, 0, 0, 0, 0)};
    vecs[7] = '{32'h00000001, 6'd32, 32'h00000000, 3'd0, 1, st(0, 0, 0, 0, 0)};
`else
    vecs[3] = '{32'hFFFFFFFF, 6'd40, 32'h00000000, 3'd3, 4, st(15, 15, 10, 0, 0)};
    vecs[4] = '{32'h00000001, 6'd63, 32'h00000000, 3'd5, 6, st(15, 15, 15, 15, 3)};
    vecs[7] = '{32'h00000001, 6'd32, 32'h00000000, 3'd3, 4, st(15, 15, 2, 0, 0)};
`endif
    vecs[5] = '{32'h12345678, 6'd15, 32'h2B3C0000, 3'd1, 2, st(15, 0, 0, 0, 0)};
    vecs[6] = '{32'h00000001, 6'd31, 32'h80000000, 3'd3, 4, st(15, 15, 1, 0, 0)};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_data   = '0;
    req_amount = '0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_passes", 32'(rsp_passes), 32'd0);
    chk("rst_sh_data_in", sh_data_in, 32'd0);
    chk("rst_sh_amount", 32'(sh_shift_amount), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // backpressure: result held, second request ignored until after the handshake
    req_data   = 32'h0000000B;
    req_amount = 6'd4;
    req_valid  = 1'b1;
    rsp_ready  = 1'b0;
    tick();
    req_data   = 32'h0000000F;
    req_amount = 6'd1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'h000000B0);
      chk("bp_rsp_passes", 32'(rsp_passes), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    chk("bp_release_ready", 32'(req_ready), 32'd0);
    tick();
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("bp2_sh_data", sh_data_in, 32'h0000000F);
    chk("bp2_sh_amount", 32'(sh_shift_amount), 32'd1);
    tick();
    chk("bp2_rsp_data", rsp_data, 32'h0000001E);
    chk("bp2_rsp_passes", 32'(rsp_passes), 32'd1);
    tick();

    // asynchronous reset during the second SHIFT cycle of a 63-position request
    req_data   = 32'h00000001;
    req_amount = 6'd63;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_sh_amount", 32'(sh_shift_amount), 32'd15);
    chk("mid_sh_data", sh_data_in, 32'h00008000);
    rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    chk("arst_rsp_passes", 32'(rsp_passes), 32'd0);
    chk("arst_sh_data_in", sh_data_in, 32'd0);
    chk("arst_sh_amount", 32'(sh_shift_amount), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_vec('{32'h00000001, 6'd1, 32'h00000002, 3'd1, 2, st(1, 0, 0, 0, 0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
